btb_predictor: RTL
==================

BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 Parameter BTB_ENTRIES, default 16, number of direct-mapped BTB entries; SHALL be a power of two, at least 2.
REQ-002 Parameter CNT_W, default 16, width of each statistics counter.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port i_valid  input  1  fetch stage presents a valid PC this cycle.
REQ-006 Port i_pc  input  PC_SIZE  PC of the instruction being fetched.
REQ-007 Port o_pred (branch_predictor_output_ifc.out)  output  1+PC_SIZE  pc_override and target to the hazard controller.
REQ-008 Port o_predict_taken  output  1  prediction tag carried down the pipeline with the instruction.
REQ-009 Port o_predict_target  output  PC_SIZE  predicted target carried down the pipeline.
REQ-010 Port i_feedback (branch_feedback_ifc.in)  input  bundle  valid, pc, target, predict_taken, feedback_taken, predict_target, feedback_target from the resolving stage.
REQ-011 Port o_branch_count  output  CNT_W  resolved branches since reset.
REQ-012 Port o_mispredict_count  output  CNT_W  mispredicts since reset.

Function
REQ-013 Each entry SHALL hold valid, tag (PC_SIZE-IDX_W bits), target (PC_SIZE), and a 2-bit counter, where IDX_W = log2(BTB_ENTRIES).
REQ-014 Index = pc[IDX_W-1:0]; tag = pc[PC_SIZE-1:IDX_W]; hit = entry.valid and tag match.
REQ-015 Lookup SHALL be combinational, zero latency: o_predict_taken = i_valid & hit & counter[1]; o_predict_target = entry.target when hit, else i_pc+1 (modulo 2^PC_SIZE).
REQ-016 o_pred.pc_override SHALL equal o_predict_taken; o_pred.target SHALL equal o_predict_target.
REQ-017 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; taken increments, not-taken decrements, saturating at 11 and 00.
REQ-018 On feedback.valid with hit at feedback.pc: update the counter; if feedback_taken, write entry.target = feedback.target.
REQ-019 On feedback.valid, miss, feedback_taken: allocate (overwrite) the entry: valid=1, new tag, target=feedback.target, counter=10.
REQ-020 On feedback.valid, miss, not taken: no table change.
REQ-021 mispredict SHALL be feedback.valid & ((predict_taken != feedback_taken) | (feedback_taken & predict_target != feedback_target)).
REQ-022 On feedback.valid, o_branch_count SHALL increment; on mispredict, o_mispredict_count SHALL increment; both saturate at all-ones.
REQ-023 Lookup and update on the same index in the same cycle: lookup SHALL return pre-update contents; the update takes effect next cycle.
REQ-024 With i_valid=0, the outputs SHALL be pc_override=0 and predict_taken=0, and the table SHALL still accept updates.

Reset
REQ-025 While rst is high, all entry valid bits, counters, and statistics counters SHALL be 0; tags and targets SHALL NOT be reset.
REQ-026 Reset asserted mid-update SHALL discard that update; the first post-reset lookup SHALL miss.

Structure
REQ-027 The shared package SHALL hold the 2-bit counter enum, the BTB entry struct typedef, and the mispredict-compare function.
REQ-028 The saturating 2-bit counter update SHALL be a sub-module sat_counter2 (combinational next-state); the table SHALL stay in btb_predictor.

Verification
REQ-029 Reset, then i_valid=1, i_pc=0x10 -> pc_override=0, target=0x11, both counts 0.
REQ-030 Feedback pc=0x10, taken, target=0x40 (miss) -> next cycle, lookup 0x10 gives pc_override=1, target=0x40, counter=10, branch_count=1.
REQ-031 Two not-taken feedbacks on 0x10 -> counter 10 to 01 to 00, pc_override=0; five taken feedbacks -> counter saturates at 11.
REQ-032 Entry at 0x10 valid, feedback taken for aliasing pc 0x20 (BTB_ENTRIES=16) -> entry replaced, lookup 0x10 misses, lookup 0x20 hits with the new target.
REQ-033 Same-cycle lookup and allocate on 0x30 -> that cycle misses, the following cycle hits.
REQ-034 Feedback with predict_taken=1, feedback_taken=1, predict_target=0x40, feedback_target=0x44 -> mispredict_count+1; force 2^CNT_W branches -> branch_count holds at all-ones.

Source files
------------

// File: rtl/btb_predictor_pkg.sv
// Shared types for the branch target buffer:
// 2-bit counter, BTB entry and mispredict compare.
package btb_predictor_pkg;

  localparam int PC_SIZE = 16;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt2_t;

  // tag holds pc >> IDX_W, zero-extended to PC_SIZE
  typedef struct packed {
    logic               valid;
    logic [PC_SIZE-1:0] tag;
    logic [PC_SIZE-1:0] target;
    cnt2_t              cnt;
  } btb_entry_t;

  function automatic logic is_mispredict(
    input logic               valid,
    input logic               pred_taken,
    input logic               fb_taken,
    input logic [PC_SIZE-1:0] pred_target,
    input logic [PC_SIZE-1:0] fb_target
  );
    return valid &&
      ((pred_taken != fb_taken) ||
       (fb_taken && pred_target != fb_target));
  endfunction

endpackage

// File: rtl/btb_predictor_ifc.sv
// Prediction output and branch feedback
// bundles between fetch, hazard and resolve.
interface branch_predictor_output_ifc;
  import btb_predictor_pkg::*;
  logic               pc_override;
  logic [PC_SIZE-1:0] target;
  modport out (output pc_override, target);
  modport in  (input  pc_override, target);
endinterface

interface branch_feedback_ifc;
  import btb_predictor_pkg::*;
  logic               valid;
  logic [PC_SIZE-1:0] pc;
  logic [PC_SIZE-1:0] target;
  logic               predict_taken;
  logic               feedback_taken;
  logic [PC_SIZE-1:0] predict_target;
  logic [PC_SIZE-1:0] feedback_target;
  modport out (
    output valid, pc, target, predict_taken,
    feedback_taken, predict_target, feedback_target
  );
  modport in (
    input valid, pc, target, predict_taken,
    feedback_taken, predict_target, feedback_target
  );
endinterface

// File: rtl/btb_predictor_sat.sv
// Saturating 2-bit taken/not-taken counter,
// next-state only.
module sat_counter2
  import btb_predictor_pkg::*;
(
  input  cnt2_t cur,
  input  logic  taken,
  output cnt2_t nxt
);

  always_comb begin
    nxt = cur;
    unique case (1'b1)
      taken && cur != CNT_ST:
        nxt = cnt2_t'(cur + 2'd1);
      !taken && cur != CNT_SNT:
        nxt = cnt2_t'(cur - 2'd1);
      default: ;
    endcase
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters,
// zero-latency lookup and branch statistics.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [PC_SIZE-1:0] i_pc,
  branch_predictor_output_ifc.out o_pred,
  output logic               o_predict_taken,
  output logic [PC_SIZE-1:0] o_predict_target,
  branch_feedback_ifc.in     i_feedback,
  output logic [CNT_W-1:0]   o_branch_count,
  output logic [CNT_W-1:0]   o_mispredict_count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_SIZE - IDX_W;

  logic [BTB_ENTRIES-1:0] valid_q;
  cnt2_t              cnt_q [BTB_ENTRIES];
  logic [TAG_W-1:0]   tag_q [BTB_ENTRIES];
  logic [PC_SIZE-1:0] tgt_q [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] fb_idx;
  btb_entry_t       rd_ent;
  btb_entry_t       fb_ent;
  logic             rd_hit;
  logic             fb_hit;
  cnt2_t            cnt_nxt;
  logic             wr_alloc;
  logic             wr_tgt;
  logic             wr_cnt;
  logic             mispredict;

  assign rd_idx = i_pc[IDX_W-1:0];
  assign fb_idx = i_feedback.pc[IDX_W-1:0];

  always_comb begin
    rd_ent.valid  = valid_q[rd_idx];
    rd_ent.tag    = PC_SIZE'(tag_q[rd_idx]);
    rd_ent.target = tgt_q[rd_idx];
    rd_ent.cnt    = cnt_q[rd_idx];
    fb_ent.valid  = valid_q[fb_idx];
    fb_ent.tag    = PC_SIZE'(tag_q[fb_idx]);
    fb_ent.target = tgt_q[fb_idx];
    fb_ent.cnt    = cnt_q[fb_idx];
  end

  assign rd_hit = rd_ent.valid &&
    rd_ent.tag == PC_SIZE'(i_pc[PC_SIZE-1:IDX_W]);
  assign fb_hit = fb_ent.valid &&
    fb_ent.tag ==
      PC_SIZE'(i_feedback.pc[PC_SIZE-1:IDX_W]);

  // table reads see pre-update state
  assign o_predict_taken =
    i_valid && rd_hit && rd_ent.cnt >= CNT_WT;
  assign o_predict_target = rd_hit ?
    rd_ent.target : i_pc + PC_SIZE'(1);
  assign o_pred.pc_override = o_predict_taken;
  assign o_pred.target      = o_predict_target;

  sat_counter2 u_sat (
    .cur   (fb_ent.cnt),
    .taken (i_feedback.feedback_taken),
    .nxt   (cnt_nxt)
  );

  assign wr_cnt   = i_feedback.valid && fb_hit;
  assign wr_tgt   = i_feedback.valid &&
                    i_feedback.feedback_taken;
  assign wr_alloc = wr_tgt && !fb_hit;

  assign mispredict = is_mispredict(
    i_feedback.valid,
    i_feedback.predict_taken,
    i_feedback.feedback_taken,
    i_feedback.predict_target,
    i_feedback.feedback_target
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++)
        cnt_q[i] <= CNT_SNT;
    end else begin
      if (wr_alloc) begin
        valid_q[fb_idx] <= 1'b1;
        cnt_q[fb_idx]   <= CNT_WT;
      end else if (wr_cnt) begin
        cnt_q[fb_idx]   <= cnt_nxt;
      end
    end
  end

  // tag/target are qualified by valid_q
  always_ff @(posedge clk) begin
    if (wr_tgt)
      tgt_q[fb_idx] <= i_feedback.target;
    if (wr_alloc)
      tag_q[fb_idx] <=
        i_feedback.pc[PC_SIZE-1:IDX_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_branch_count     <= '0;
      o_mispredict_count <= '0;
    end else begin
      if (i_feedback.valid &&
          o_branch_count != '1)
        o_branch_count <=
          o_branch_count + CNT_W'(1);
      if (mispredict &&
          o_mispredict_count != '1)
        o_mispredict_count <=
          o_mispredict_count + CNT_W'(1);
    end
  end

endmodule
